// File: rtl/matrix_vector_mac.sv
// Vector x matrix engine: v = u*A (or u*A^T), one shared multiplier iterated over DIM*DIM MACs.
// Latency: out_valid rises DIM*DIM cycles after the accept edge; min period DIM*DIM+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready stays low until the result is taken.

`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 8
`endif

module matrix_vector_mac #(
    parameter int DIM      = 2,
    parameter int WIDTH    = `FLOAT_BITS,
    parameter int FRAC     = `FLOAT_DCM_BITS,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       transpose,
    input  logic [DIM*WIDTH-1:0]       u,
    input  logic [DIM*DIM*WIDTH-1:0]   a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIM*WIDTH-1:0]       v
);

    localparam int IW = $clog2(DIM);
    localparam int PW = 2 * WIDTH;
    // One extra bit per doubling of DIM keeps the running sum from overflowing.
    localparam int AW = PW + IW;
    localparam logic [IW-1:0] LAST = IW'(DIM - 1);
    localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                   state_q;
    logic signed [WIDTH-1:0]  u_q [DIM];
    logic signed [WIDTH-1:0]  a_q [DIM][DIM];
    logic                     tr_q;
    logic [IW-1:0]            c_q;
    logic [IW-1:0]            r_q;
    logic signed [AW-1:0]     acc_q;
    logic signed [WIDTH-1:0]  v_q [DIM];
    logic                     out_valid_q;

    logic signed [WIDTH-1:0]  u_el;
    logic signed [WIDTH-1:0]  m_el;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     term;
    logic signed [AW-1:0]     sum_d;
    logic signed [WIDTH-1:0]  fin_d;

    // Current MAC term: the shift is applied per term (floor), before accumulation.
    always_comb begin
        u_el  = u_q[r_q];
        m_el  = tr_q ? a_q[c_q][r_q] : a_q[r_q][c_q];
        prod  = $signed({{WIDTH{u_el[WIDTH-1]}}, u_el}) * $signed({{WIDTH{m_el[WIDTH-1]}}, m_el});
        term  = prod >>> FRAC;
        sum_d = acc_q + {{IW{term[PW-1]}}, term};
    end

    // Reduce the full-width column sum to WIDTH bits: wrap, or clamp when saturating.
    always_comb begin
        fin_d = sum_d[WIDTH-1:0];
        if (SATURATE != 0) begin
            if (sum_d > SMAX) begin
                fin_d = SMAX[WIDTH-1:0];
            end else if (sum_d < SMIN) begin
                fin_d = SMIN[WIDTH-1:0];
            end
        end
    end

    // Control FSM plus operand, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tr_q        <= 1'b0;
            c_q         <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                u_q[i] <= '0;
                v_q[i] <= '0;
                for (int j = 0; j < DIM; j++) begin
                    a_q[i][j] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < DIM; i++) begin
                            u_q[i] <= u[i*WIDTH +: WIDTH];
                            for (int j = 0; j < DIM; j++) begin
                                a_q[i][j] <= a[(i*DIM+j)*WIDTH +: WIDTH];
                            end
                        end
                        tr_q    <= transpose;
                        acc_q   <= '0;
                        c_q     <= '0;
                        r_q     <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_q == LAST) begin
                        // Column complete: commit it and start the next one from zero.
                        v_q[c_q] <= fin_d;
                        acc_q    <= '0;
                        r_q      <= '0;
                        if (c_q == LAST) begin
                            c_q         <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            c_q <= c_q + IW'(1);
                        end
                    end else begin
                        acc_q <= sum_d;
                        r_q   <= r_q + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;

    for (genvar gi = 0; gi < DIM; gi++) begin : g_vpack
        assign v[gi*WIDTH +: WIDTH] = v_q[gi];
    end

endmodule

// File: tb/tb_matrix_vector_mac.sv
// Directed bench for matrix_vector_mac (DIM=2, WIDTH=16, FRAC=8), wrap and saturate instances.
// Expected values are hand-computed Q8.8 products.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.

module tb_matrix_vector_mac;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           transpose;
    logic           out_ready;
    logic [2*W-1:0] u;
    logic [4*W-1:0] a;
    logic           in_ready, in_ready_s;
    logic           out_valid, out_valid_s;
    logic [2*W-1:0] v, v_s;

    int n_run  = 0;
    int n_fail = 0;
    int lat;

    always #5 clk = ~clk;

    matrix_vector_mac #(.DIM(2), .WIDTH(W), .FRAC(8), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .transpose(transpose), .u(u), .a(a), .out_valid(out_valid),
        .out_ready(out_ready), .v(v)
    );

    matrix_vector_mac #(.DIM(2), .WIDTH(W), .FRAC(8), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .transpose(transpose), .u(u), .a(a), .out_valid(out_valid_s),
        .out_ready(out_ready), .v(v_s)
    );

    task automatic check_val(input string tag, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic signed [31:0] el(input logic [2*W-1:0] vv, input int i);
        logic signed [W-1:0] x;
        x = vv[i*W +: W];
        return 32'(x);
    endfunction

    // Present operands for one accept edge, then scramble them and wait for the result.
    task automatic send(input logic signed [W-1:0] u0, input logic signed [W-1:0] u1,
                        input logic signed [W-1:0] a00, input logic signed [W-1:0] a01,
                        input logic signed [W-1:0] a10, input logic signed [W-1:0] a11,
                        input logic tr, output int cyc);
        u         = {u1, u0};
        a         = {a11, a10, a01, a00};
        transpose = tr;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        u         = $urandom;
        a         = {$urandom, $urandom};
        transpose = ~tr;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits [3];
        int nh;
        int both;

        rst_n = 1'b0; in_valid = 1'b0; transpose = 1'b0; out_ready = 1'b0;
        u = '0; a = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 1);
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_v", 32'(v), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic product
        check_val("basic_rdy_before", 32'(in_ready), 1);
        send(256, 512, 256, 512, 768, 1024, 1'b0, lat);
        check_val("basic_latency", lat, 4);
        check_val("basic_v0", el(v, 0), 1792);
        check_val("basic_v1", el(v, 1), 2560);
        check_val("basic_no_rdy", 32'(in_ready), 0);
        take_result();

        // Transpose
        send(256, 512, 256, 512, 768, 1024, 1'b1, lat);
        check_val("tr_latency", lat, 4);
        check_val("tr_v0", el(v, 0), 1280);
        check_val("tr_v1", el(v, 1), 2816);
        take_result();

        // Per-term floor
        send(-1, -1, 1, 1, 1, 1, 1'b0, lat);
        check_val("floor_v0", el(v, 0), -2);
        check_val("floor_v1", el(v, 1), -2);
        take_result();

        // Overflow: wrap vs clamp
        send(32512, 32512, 256, 0, 256, 0, 1'b0, lat);
        check_val("ovf_wrap_v0", el(v, 0), -512);
        check_val("ovf_wrap_v1", el(v, 1), 0);
        check_val("ovf_sat_valid", 32'(out_valid_s), 1);
        check_val("ovf_sat_v0", el(v_s, 0), 32767);
        check_val("ovf_sat_v1", el(v_s, 1), 0);
        take_result();

        // Backpressure: result held, new operands ignored
        send(256, 512, 256, 512, 768, 1024, 1'b0, lat);
        check_val("bp_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid  = ~in_valid;
            u         = $urandom;
            a         = {$urandom, $urandom};
            transpose = $urandom_range(0, 1);
            @(posedge clk); #1;
            check_val("bp_out_valid", 32'(out_valid), 1);
            check_val("bp_in_ready", 32'(in_ready), 0);
            check_val("bp_v0", el(v, 0), 1792);
            check_val("bp_v1", el(v, 1), 2560);
        end
        in_valid = 1'b0;
        take_result();
        check_val("rel_in_ready", 32'(in_ready), 1);
        check_val("rel_out_valid", 32'(out_valid), 0);
        check_val("rel_v0_held", el(v, 0), 1792);

        // Back-to-back vectors with the consumer always ready
        u = {16'sd512, 16'sd256};
        a = {16'sd1024, 16'sd768, 16'sd512, 16'sd256};
        transpose = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nh = 0; both = 0;
        hits[0] = 0; hits[1] = 0; hits[2] = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (in_ready && out_valid) both++;
            if (out_valid && nh < 3) begin
                hits[nh] = cyc;
                check_val("b2b_v0", el(v, 0), 1792);
                check_val("b2b_v1", el(v, 1), 2560);
                nh++;
            end
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("b2b_count", nh, 3);
        check_val("b2b_first", hits[0], 5);
        check_val("b2b_period1", hits[1] - hits[0], 6);
        check_val("b2b_period2", hits[2] - hits[1], 6);
        check_val("b2b_rdy_and_vld", both, 0);
        check_val("b2b_idle", 32'(in_ready), 1);

        // Reset two cycles into a computation
        u = {16'sd32512, 16'sd32512};
        a = {16'sd0, 16'sd256, 16'sd0, 16'sd256};
        transpose = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_out_valid", 32'(out_valid), 0);
        check_val("mrst_v", 32'(v), 0);
        check_val("mrst_v_sat", 32'(v_s), 0);
        check_val("mrst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("mrst_post_valid", 32'(out_valid), 0);
        send(256, 512, 256, 512, 768, 1024, 1'b1, lat);
        check_val("mrst_latency", lat, 4);
        check_val("mrst_v0", el(v, 0), 1280);
        check_val("mrst_v1", el(v, 1), 2816);
        take_result();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
